// File: rtl/rptr_level_handler_pkg.sv
// Shared definitions for the async FIFO pointer handlers (read and write side).
package rptr_level_handler_pkg;

    localparam int unsigned C_ADDR_W = 4;

    // Width-agnostic: zero-extend the operand, then truncate the result back to the pointer width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/rptr_level_handler_if.sv
// Consumer-side bus of the FIFO read handler: read request, flags, level and RAM address.
interface rptr_level_handler_if
    import rptr_level_handler_pkg::*;
#(
    parameter int unsigned P_ADDR_W = C_ADDR_W,
    parameter int unsigned P_PTR_W  = P_ADDR_W + 1
) ();

    logic                i_r_en;
    logic [P_PTR_W-1:0]  i_g_wptr_sync;
    logic [P_PTR_W-1:0]  i_ae_thr;
    logic                i_clr_err;
    logic [P_ADDR_W-1:0] o_raddr;
    logic [P_PTR_W-1:0]  o_g_rptr;
    logic                o_empty;
    logic                o_almost_empty;
    logic [P_PTR_W-1:0]  o_level;
    logic                o_rd_valid;
    logic                o_underflow;
    logic                o_underflow_sticky;

    modport master (
        output i_r_en, i_g_wptr_sync, i_ae_thr, i_clr_err,
        input  o_raddr, o_g_rptr, o_empty, o_almost_empty, o_level,
               o_rd_valid, o_underflow, o_underflow_sticky
    );

    modport slave (
        input  i_r_en, i_g_wptr_sync, i_ae_thr, i_clr_err,
        output o_raddr, o_g_rptr, o_empty, o_almost_empty, o_level,
               o_rd_valid, o_underflow, o_underflow_sticky
    );

endinterface

// File: rtl/rptr_level_handler_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or above it.
module gray2bin
    import rptr_level_handler_pkg::*;
#(
    parameter int unsigned P_PTR_W = C_ADDR_W + 1
) (
    input  logic [P_PTR_W-1:0] i_gray,
    output logic [P_PTR_W-1:0] o_bin
);

    for (genvar i = 0; i < P_PTR_W; i++) begin : g_bit
        assign o_bin[i] = ^i_gray[P_PTR_W-1:i];
    end

endmodule

// File: rtl/rptr_level_handler.sv
// Read-side pointer handler of an async FIFO: Gray read pointer, empty/almost-empty, level and underflow.
module rptr_level_handler
    import rptr_level_handler_pkg::*;
#(
    parameter int unsigned P_ADDR_W = C_ADDR_W,
    parameter int unsigned P_PTR_W  = P_ADDR_W + 1
) (
    input  logic               rclk,
    input  logic               rrst,
    rptr_level_handler_if.slave bus
);

    logic [P_PTR_W-1:0] b_rptr;
    logic [P_PTR_W-1:0] b_next;
    logic [P_PTR_W-1:0] g_next;
    logic [P_PTR_W-1:0] wptr_bin;
    logic [P_PTR_W-1:0] level_next;
    logic [P_PTR_W-1:0] g_rptr_q;
    logic [P_PTR_W-1:0] level_q;
    logic               accept;
    logic               underflow_now;
    logic               empty_q;
    logic               ae_q;
    logic               rd_valid_q;
    logic               underflow_q;
    logic               sticky_q;

    gray2bin #(.P_PTR_W(P_PTR_W)) u_gray2bin (
        .i_gray (bus.i_g_wptr_sync),
        .o_bin  (wptr_bin)
    );

    assign accept        = bus.i_r_en & ~empty_q;
    assign underflow_now = bus.i_r_en & empty_q;
    assign b_next        = b_rptr + P_PTR_W'(accept);
    assign g_next        = P_PTR_W'(bin2gray(32'(b_next)));
    // Modular subtraction stays exact across the wrap bit for occupancies 0..depth.
    assign level_next    = wptr_bin - b_next;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            b_rptr      <= '0;
            g_rptr_q    <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            ae_q        <= 1'b1;
            rd_valid_q  <= 1'b0;
            underflow_q <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            b_rptr      <= b_next;
            g_rptr_q    <= g_next;
            empty_q     <= (bus.i_g_wptr_sync == g_next);
            level_q     <= level_next;
            ae_q        <= (level_next <= bus.i_ae_thr);
            rd_valid_q  <= accept;
            underflow_q <= underflow_now;
            // A new underflow wins over a clear arriving in the same cycle.
            if (underflow_now) begin
                sticky_q <= 1'b1;
            end else if (bus.i_clr_err) begin
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.o_raddr            = b_rptr[P_ADDR_W-1:0];
    assign bus.o_g_rptr           = g_rptr_q;
    assign bus.o_empty            = empty_q;
    assign bus.o_almost_empty     = ae_q;
    assign bus.o_level            = level_q;
    assign bus.o_rd_valid         = rd_valid_q;
    assign bus.o_underflow        = underflow_q;
    assign bus.o_underflow_sticky = sticky_q;

endmodule

// File: doc/rptr_level_handler.md
RPTR_LEVEL_HANDLER -- requirements
Module: rptr_level_handler

Interface
REQ-001 SHALL have parameter P_ADDR_W, default 4, meaning the FIFO address width (depth = 2^P_ADDR_W, P_ADDR_W >= 2).
REQ-002 SHALL have parameter P_PTR_W, default P_ADDR_W+1, meaning the pointer width including the wrap bit (not overridden).
REQ-003 SHALL have port rclk, input, 1, the single read-domain clock; all logic is on its rising edge.
REQ-004 SHALL have port rrst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port i_r_en, input, 1, read request from the consumer.
REQ-006 SHALL have port i_g_wptr_sync, input, P_PTR_W, Gray write pointer already synchronised into rclk.
REQ-007 SHALL have port i_ae_thr, input, P_PTR_W, almost-empty threshold (quasi-static).
REQ-008 SHALL have port i_clr_err, input, 1, clears the sticky underflow flag.
REQ-009 SHALL have port o_raddr, output, P_ADDR_W, RAM read address.
REQ-010 SHALL have port o_g_rptr, output, P_PTR_W, registered Gray read pointer for the write-domain synchroniser.
REQ-011 SHALL have port o_empty, output, 1, registered empty flag.
REQ-012 SHALL have port o_almost_empty, output, 1, registered flag, high when level <= i_ae_thr.
REQ-013 SHALL have port o_level, output, P_PTR_W, registered occupancy 0..2^P_ADDR_W.
REQ-014 SHALL have port o_rd_valid, output, 1, high one cycle after an accepted read (RAM data valid).
REQ-015 SHALL have port o_underflow, output, 1, one-cycle pulse on a rejected read.
REQ-016 SHALL have port o_underflow_sticky, output, 1, latched underflow.

Function
REQ-017 SHALL define accept = i_r_en & !o_empty; binary pointer next = b_rptr + accept, modulo 2^P_PTR_W.
REQ-018 SHALL compute Gray next = (b_next >> 1) ^ b_next and register it to o_g_rptr with b_rptr in the same edge.
REQ-019 SHALL drive o_raddr = b_rptr[P_ADDR_W-1:0] from the register (no combinational path from i_r_en).
REQ-020 SHALL convert i_g_wptr_sync to binary combinationally (MSB-down XOR chain).
REQ-021 SHALL register o_empty <= (i_g_wptr_sync == Gray next).
REQ-022 SHALL register o_level <= (wptr_bin - b_next) modulo 2^P_PTR_W; result is exact for 0..2^P_ADDR_W.
REQ-023 SHALL register o_almost_empty <= (level_next <= i_ae_thr); i_ae_thr = 0 makes it equal to empty.
REQ-024 SHALL register o_rd_valid <= accept (latency 1 from i_r_en).
REQ-025 SHALL register o_underflow <= i_r_en & o_empty; pointer SHALL NOT move on a rejected read.
REQ-026 SHALL set o_underflow_sticky on any underflow; i_clr_err clears it; simultaneous set and clear SHALL leave it set.
REQ-027 SHALL handle pointer wrap seamlessly: wrap bit toggles, address returns to 0, no flag glitch.
REQ-028 SHALL treat a write-pointer change arriving on the same edge as the last read correctly: empty deasserts, level reflects both.

Reset
REQ-029 SHALL on rrst asserted, asynchronously force b_rptr=0, o_g_rptr=0, o_raddr=0, o_level=0, o_empty=1, o_almost_empty=1, o_rd_valid=0, o_underflow=0, o_underflow_sticky=0.
REQ-030 SHALL abandon any read in flight when reset asserts mid-operation; no o_rd_valid after reset deasserts until a new accepted read.
REQ-031 SHALL require rrst deassertion synchronous to rclk (external reset synchroniser).

Structure
REQ-032 SHALL place a shared Gray/binary conversion function and the default P_ADDR_W constant in the common FIFO package used by the write-side handler.
REQ-033 SHALL instantiate one sub-module gray2bin (parametrised by P_PTR_W) for REQ-020; all other logic stays in rptr_level_handler.

Verification (P_ADDR_W=3, depth 8)
REQ-034 SHALL test reset: rrst pulse mid-stream -> all outputs at REQ-029 values immediately, o_empty=1, o_level=0.
REQ-035 SHALL test fill/drain: wptr Gray=binary 5, i_ae_thr=2, five reads back-to-back -> o_level 5,4,3,2,1,0; o_almost_empty rises at level 2; o_empty rises after 5th read; 5 o_rd_valid pulses.
REQ-036 SHALL test full occupancy: wptr binary 8, rptr 0 -> o_level=8, o_empty=0.
REQ-037 SHALL test underflow: i_r_en high while empty -> o_underflow one-cycle pulse, o_raddr unchanged, sticky=1 until i_clr_err; clear+underflow same cycle -> sticky stays 1.
REQ-038 SHALL test wrap: 20 writes/reads interleaved -> b_rptr passes 15->0, o_g_rptr 4'b1000->4'b0000, o_raddr 7->0, no spurious empty.
REQ-039 SHALL test simultaneous events: last read with wptr increment same cycle -> o_empty stays 0, o_level stays 1.
